multicycle_main_controller: RTL and testbench

- Main control FSM for the multi-cycle RV32I datapath. It sits directly upstream of the ALU controller.
- It sequences FETCH/DECODE/EXECUTE/MEM/WB steps from the instruction register's op, funct3 and the ALU zero flag.
- It drives every datapath enable and mux select, plus a 2-bit alu_op that the ALU controller expands into the ALU function.
- Supported instructions: add, sub, and, or, slt, addi, andi, ori, slti, lw, sw, beq, bne, jal, jalr, lui.

---
 rtl/multicycle_main_controller_pkg.sv | 68 ++++++
 rtl/multicycle_main_controller_imm_src_decoder.sv | 20 ++
 rtl/multicycle_main_controller.sv | 168 ++++++++++++++++
 tb/tb_multicycle_main_controller.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_main_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM state codes and datapath selects.
// The HALT state exists only when MULTICYCLE_ILLEGAL_HALT_EN is defined.
package multicycle_main_controller_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH     = 4'd0;
  localparam state_t S_DECODE    = 4'd1;
  localparam state_t S_MEM_ADR   = 4'd2;
  localparam state_t S_MEM_READ  = 4'd3;
  localparam state_t S_MEM_WB    = 4'd4;
  localparam state_t S_MEM_WRITE = 4'd5;
  localparam state_t S_EXEC_R    = 4'd6;
  localparam state_t S_EXEC_I    = 4'd7;
  localparam state_t S_ALU_WB    = 4'd8;
  localparam state_t S_BRANCH    = 4'd9;
  localparam state_t S_JAL       = 4'd10;
  localparam state_t S_JALR_ADR  = 4'd11;
  localparam state_t S_LUI       = 4'd12;
  localparam state_t S_ILLEGAL   = 4'd13;
`ifdef MULTICYCLE_ILLEGAL_HALT_EN
  localparam state_t S_HALT      = 4'd14;
`endif

  typedef enum logic [1:0] {
    RESULT_ALUOUT    = 2'b00,
    RESULT_DATA      = 2'b01,
    RESULT_ALURESULT = 2'b10,
    RESULT_IMMEXT    = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    SRC_A_PC     = 2'b00,
    SRC_A_OLD_PC = 2'b01,
    SRC_A_RS1    = 2'b10
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'b00,
    SRC_B_IMM  = 2'b01,
    SRC_B_FOUR = 2'b10
  } alu_src_b_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  // The ALU controller decodes these same values.
  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_e;

endpackage

// File: rtl/multicycle_main_controller_imm_src_decoder.sv
// Pure combinational opcode to immediate-format mapping, shared with the single-cycle datapath.
module imm_src_decoder
  import multicycle_main_controller_pkg::*;
(
  input  logic [6:0] op,
  output logic [2:0] imm_src
);

  always_comb begin
    case (op)
      OP_LOAD, OP_I, OP_JALR: imm_src = IMM_I;
      OP_S:                   imm_src = IMM_S;
      OP_B:                   imm_src = IMM_B;
      OP_JAL:                 imm_src = IMM_J;
      OP_LUI:                 imm_src = IMM_U;
      default:                imm_src = 3'b000;
    endcase
  end

endmodule

// File: rtl/multicycle_main_controller.sv
// Main control FSM of the multi-cycle RV32I datapath; MEM_WAIT (0..3) stretches FETCH and MEM_READ.
// Define MULTICYCLE_ILLEGAL_HALT_EN to park unknown opcodes in an absorbing HALT state with a sticky flag.
module multicycle_main_controller
  import multicycle_main_controller_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [1:0] WAIT_LAST = 2'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       last_beat;

  assign last_beat = (cnt_q == WAIT_LAST);
  assign state     = state_q;

  imm_src_decoder u_imm_src_decoder (
    .op      (op),
    .imm_src (imm_src)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (last_beat) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_S: state_d = S_MEM_ADR;
          OP_R:          state_d = S_EXEC_R;
          OP_I:          state_d = S_EXEC_I;
          OP_B:          state_d = S_BRANCH;
          OP_JAL:        state_d = S_JAL;
          OP_JALR:       state_d = S_JALR_ADR;
          OP_LUI:        state_d = S_LUI;
          default:       state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADR:  state_d = (op == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: if (last_beat) state_d = S_MEM_WB;
      S_EXEC_R, S_EXEC_I, S_JAL: state_d = S_ALU_WB;
      S_JALR_ADR: state_d = S_JAL;
`ifdef MULTICYCLE_ILLEGAL_HALT_EN
      S_ILLEGAL:  state_d = S_HALT;
      S_HALT:     state_d = S_HALT;
`endif
      default:    state_d = S_FETCH;
    endcase

    // The counter only advances while dwelling in a waiting state, so it restarts at 0 on every entry.
    cnt_d = 2'd0;
    if ((state_q == state_d) && ((state_q == S_FETCH) || (state_q == S_MEM_READ)))
      cnt_d = cnt_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MULTICYCLE_ILLEGAL_HALT_EN
  logic illegal_q, illegal_d;

  always_comb illegal_d = illegal_q | (state_d == S_HALT);

  always_ff @(posedge clk) begin
    if (!rst) illegal_q <= 1'b0;
    else      illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RESULT_ALUOUT;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALU_OP_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRC_B_FOUR;
        result_src = RESULT_ALURESULT;
        ir_write   = last_beat;
        pc_write   = last_beat;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_ADR, S_JALR_ADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_READ:  adr_src = 1'b1;
      S_MEM_WB: begin
        result_src = RESULT_DATA;
        reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_OP_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_OP_FUNCT;
      end
      S_ALU_WB:    reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_OP_SUB;
        case (funct3)
          3'b000:  pc_write = zero;
          3'b001:  pc_write = !zero;
          default: pc_write = 1'b0;
        endcase
      end
      // JAL loads the target computed in DECODE/JALR_ADR while forming OldPC+4 for the link.
      S_JAL: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_FOUR;
        pc_write  = 1'b1;
      end
      S_LUI: begin
        result_src = RESULT_IMMEXT;
        reg_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Directed bench for multicycle_main_controller with MEM_WAIT=0 and MEM_WAIT=2 instances side by side.
// Illegal-opcode expectations follow MULTICYCLE_ILLEGAL_HALT_EN.
module tb_multicycle_main_controller;
  import multicycle_main_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic       zero = 1'b0;

  logic       d0_pc_write, d0_adr_src, d0_mem_write, d0_ir_write, d0_reg_write, d0_illegal;
  logic [1:0] d0_result_src, d0_alu_src_a, d0_alu_src_b, d0_alu_op;
  logic [2:0] d0_imm_src;
  logic [3:0] d0_state;
  logic       d2_pc_write, d2_adr_src, d2_mem_write, d2_ir_write, d2_reg_write, d2_illegal;
  logic [1:0] d2_result_src, d2_alu_src_a, d2_alu_src_b, d2_alu_op;
  logic [2:0] d2_imm_src;
  logic [3:0] d2_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_main_controller #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero),
    .pc_write(d0_pc_write), .adr_src(d0_adr_src), .mem_write(d0_mem_write),
    .ir_write(d0_ir_write), .reg_write(d0_reg_write), .result_src(d0_result_src),
    .alu_src_a(d0_alu_src_a), .alu_src_b(d0_alu_src_b), .imm_src(d0_imm_src),
    .alu_op(d0_alu_op), .illegal(d0_illegal), .state(d0_state)
  );

  multicycle_main_controller #(.MEM_WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero),
    .pc_write(d2_pc_write), .adr_src(d2_adr_src), .mem_write(d2_mem_write),
    .ir_write(d2_ir_write), .reg_write(d2_reg_write), .result_src(d2_result_src),
    .alu_src_a(d2_alu_src_a), .alu_src_b(d2_alu_src_b), .imm_src(d2_imm_src),
    .alu_op(d2_alu_op), .illegal(d2_illegal), .state(d2_state)
  );

  // Observed vector: {state, pc_write, adr_src, mem_write, ir_write, reg_write,
  //                   result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal}
  logic [20:0] obs0, obs2;
  assign obs0 = {d0_state, d0_pc_write, d0_adr_src, d0_mem_write, d0_ir_write, d0_reg_write,
                 d0_result_src, d0_alu_src_a, d0_alu_src_b, d0_alu_op, d0_imm_src, d0_illegal};
  assign obs2 = {d2_state, d2_pc_write, d2_adr_src, d2_mem_write, d2_ir_write, d2_reg_write,
                 d2_result_src, d2_alu_src_a, d2_alu_src_b, d2_alu_op, d2_imm_src, d2_illegal};

  // Per-state control bodies {pcw,adr,memw,irw,regw, result_src, src_a, src_b, alu_op}
  localparam logic [12:0] B_FETCH_GO   = {5'b10010, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam logic [12:0] B_FETCH_WAIT = {5'b00000, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam logic [12:0] B_DECODE     = {5'b00000, 2'b00, 2'b01, 2'b01, 2'b00};
  localparam logic [12:0] B_MEM_ADR    = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00};
  localparam logic [12:0] B_MEM_READ   = {5'b01000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [12:0] B_MEM_WB     = {5'b00001, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [12:0] B_MEM_WRITE  = {5'b01100, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [12:0] B_EXEC_R     = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b10};
  localparam logic [12:0] B_EXEC_I     = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b10};
  localparam logic [12:0] B_ALU_WB     = {5'b00001, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [12:0] B_BR_TAKEN   = {5'b10000, 2'b00, 2'b10, 2'b00, 2'b01};
  localparam logic [12:0] B_BR_NOT     = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b01};
  localparam logic [12:0] B_JAL        = {5'b10000, 2'b00, 2'b01, 2'b10, 2'b00};
  localparam logic [12:0] B_JALR_ADR   = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00};
  localparam logic [12:0] B_LUI        = {5'b00001, 2'b11, 2'b00, 2'b00, 2'b00};
  localparam logic [12:0] B_IDLE       = 13'b0;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        r;
    logic [20:0] exp;
  } step_t;

  step_t      steps[$];
  logic [6:0] t_op  = 7'b0;
  logic [2:0] t_f3  = 3'b0;
  logic       t_z   = 1'b0;
  logic       t_rst = 1'b1;
  logic [2:0] t_imm = 3'b0;

  task automatic instr(input logic [6:0] o, input logic [2:0] imm);
    t_op  = o;
    t_imm = imm;
  endtask

  task automatic push(input logic [3:0] st, input logic [12:0] body, input logic ill);
    step_t s;
    s.op  = t_op;
    s.f3  = t_f3;
    s.z   = t_z;
    s.r   = t_rst;
    s.exp = {st, body, t_imm, ill};
    steps.push_back(s);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    op = 7'b0110011;
    do_reset();
    #1;
    n_tests++;
    if (obs0 !== {S_FETCH, B_FETCH_GO, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_w0: got %h, want %h", obs0, {S_FETCH, B_FETCH_GO, 3'b000, 1'b0});
    end
    n_tests++;
    if (obs2 !== {S_FETCH, B_FETCH_WAIT, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_w2: got %h, want %h", obs2, {S_FETCH, B_FETCH_WAIT, 3'b000, 1'b0});
    end
    @(negedge clk);
  endtask

  task automatic test_r_type();
    steps.delete();
    instr(7'b0110011, 3'b000);
    push(S_FETCH, B_FETCH_GO, 1'b0);
    push(S_DECODE, B_DECODE, 1'b0);
    push(S_EXEC_R, B_EXEC_R, 1'b0);
    push(S_ALU_WB, B_ALU_WB, 1'b0);
    push(S_FETCH, B_FETCH_GO, 1'b0);
    do_reset();
    foreach (steps[i]) begin
      op = steps[i].op; funct3 = steps[i].f3; zero = steps[i].z; rst = steps[i].r; #1;
      n_tests++;
      if (obs0 !== steps[i].exp) begin
        n_fail++;
        $display("FAIL r_type step %0d: got %h, want %h", i, obs0, steps[i].exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lw_wait();
    steps.delete();
    instr(7'b0000011, 3'b000);
    push(S_FETCH, B_FETCH_WAIT, 1'b0);
    push(S_FETCH, B_FETCH_WAIT, 1'b0);
    push(S_FETCH, B_FETCH_GO, 1'b0);
    push(S_DECODE, B_DECODE, 1'b0);
    push(S_MEM_ADR, B_MEM_ADR, 1'b0);
    push(S_MEM_READ, B_MEM_READ, 1'b0);
    push(S_MEM_READ, B_MEM_READ, 1'b0);
    push(S_MEM_READ, B_MEM_READ, 1'b0);
    push(S_MEM_WB, B_MEM_WB, 1'b0);
    push(S_FETCH, B_FETCH_WAIT, 1'b0);
    do_reset();
    foreach (steps[i]) begin
      op = steps[i].op; funct3 = steps[i].f3; zero = steps[i].z; rst = steps[i].r; #1;
      n_tests++;
      if (obs2 !== steps[i].exp) begin
        n_fail++;
        $display("FAIL lw_wait2 step %0d: got %h, want %h", i, obs2, steps[i].exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [2:0]  f3s [5] = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b101};
    logic        zs  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [12:0] brs [5] = '{B_BR_TAKEN, B_BR_NOT, B_BR_NOT, B_BR_TAKEN, B_BR_NOT};
    steps.delete();
    instr(7'b1100011, 3'b010);
    for (int k = 0; k < 5; k++) begin
      t_f3 = f3s[k];
      t_z  = zs[k];
      push(S_FETCH, B_FETCH_GO, 1'b0);
      push(S_DECODE, B_DECODE, 1'b0);
      push(S_BRANCH, brs[k], 1'b0);
    end
    push(S_FETCH, B_FETCH_GO, 1'b0);
    t_f3 = 3'b000;
    t_z  = 1'b0;
    do_reset();
    foreach (steps[i]) begin
      op = steps[i].op; funct3 = steps[i].f3; zero = steps[i].z; rst = steps[i].r; #1;
      n_tests++;
      if (obs0 !== steps[i].exp) begin
        n_fail++;
        $display("FAIL branch step %0d: got %h, want %h", i, obs0, steps[i].exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_jalr();
    steps.delete();
    instr(7'b1100111, 3'b000);
    push(S_FETCH, B_FETCH_GO, 1'b0);
    push(S_DECODE, B_DECODE, 1'b0);
    push(S_JALR_ADR, B_JALR_ADR, 1'b0);
    push(S_JAL, B_JAL, 1'b0);
    push(S_ALU_WB, B_ALU_WB, 1'b0);
    push(S_FETCH, B_FETCH_GO, 1'b0);
    do_reset();
    foreach (steps[i]) begin
      op = steps[i].op; funct3 = steps[i].f3; zero = steps[i].z; rst = steps[i].r; #1;
      n_tests++;
      if (obs0 !== steps[i].exp) begin
        n_fail++;
        $display("FAIL jalr step %0d: got %h, want %h", i, obs0, steps[i].exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    steps.delete();
    instr(7'b0010011, 3'b000);
    push(S_FETCH, B_FETCH_GO, 1'b0);
    push(S_DECODE, B_DECODE, 1'b0);
    push(S_EXEC_I, B_EXEC_I, 1'b0);
    push(S_ALU_WB, B_ALU_WB, 1'b0);
    instr(7'b0110111, 3'b100);
    push(S_FETCH, B_FETCH_GO, 1'b0);
    push(S_DECODE, B_DECODE, 1'b0);
    push(S_LUI, B_LUI, 1'b0);
    instr(7'b1101111, 3'b011);
    push(S_FETCH, B_FETCH_GO, 1'b0);
    push(S_DECODE, B_DECODE, 1'b0);
    push(S_JAL, B_JAL, 1'b0);
    push(S_ALU_WB, B_ALU_WB, 1'b0);
    instr(7'b0100011, 3'b001);
    push(S_FETCH, B_FETCH_GO, 1'b0);
    push(S_DECODE, B_DECODE, 1'b0);
    push(S_MEM_ADR, B_MEM_ADR, 1'b0);
    push(S_MEM_WRITE, B_MEM_WRITE, 1'b0);
    instr(7'b0000011, 3'b000);
    push(S_FETCH, B_FETCH_GO, 1'b0);
    push(S_DECODE, B_DECODE, 1'b0);
    push(S_MEM_ADR, B_MEM_ADR, 1'b0);
    push(S_MEM_READ, B_MEM_READ, 1'b0);
    push(S_MEM_WB, B_MEM_WB, 1'b0);
    push(S_FETCH, B_FETCH_GO, 1'b0);
    do_reset();
    foreach (steps[i]) begin
      op = steps[i].op; funct3 = steps[i].f3; zero = steps[i].z; rst = steps[i].r; #1;
      n_tests++;
      if (obs0 !== steps[i].exp) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got %h, want %h", i, obs0, steps[i].exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_store();
    steps.delete();
    instr(7'b0100011, 3'b001);
    push(S_FETCH, B_FETCH_GO, 1'b0);
    push(S_DECODE, B_DECODE, 1'b0);
    push(S_MEM_ADR, B_MEM_ADR, 1'b0);
    t_rst = 1'b0;
    push(S_MEM_WRITE, B_MEM_WRITE, 1'b0);
    t_rst = 1'b1;
    push(S_FETCH, B_FETCH_GO, 1'b0);
    push(S_DECODE, B_DECODE, 1'b0);
    do_reset();
    foreach (steps[i]) begin
      op = steps[i].op; funct3 = steps[i].f3; zero = steps[i].z; rst = steps[i].r; #1;
      n_tests++;
      if (obs0 !== steps[i].exp) begin
        n_fail++;
        $display("FAIL reset_mid_store step %0d: got %h, want %h", i, obs0, steps[i].exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_read();
    steps.delete();
    instr(7'b0000011, 3'b000);
    push(S_FETCH, B_FETCH_WAIT, 1'b0);
    push(S_FETCH, B_FETCH_WAIT, 1'b0);
    push(S_FETCH, B_FETCH_GO, 1'b0);
    push(S_DECODE, B_DECODE, 1'b0);
    push(S_MEM_ADR, B_MEM_ADR, 1'b0);
    push(S_MEM_READ, B_MEM_READ, 1'b0);
    t_rst = 1'b0;
    push(S_MEM_READ, B_MEM_READ, 1'b0);
    t_rst = 1'b1;
    push(S_FETCH, B_FETCH_WAIT, 1'b0);
    push(S_FETCH, B_FETCH_WAIT, 1'b0);
    push(S_FETCH, B_FETCH_GO, 1'b0);
    push(S_DECODE, B_DECODE, 1'b0);
    do_reset();
    foreach (steps[i]) begin
      op = steps[i].op; funct3 = steps[i].f3; zero = steps[i].z; rst = steps[i].r; #1;
      n_tests++;
      if (obs2 !== steps[i].exp) begin
        n_fail++;
        $display("FAIL reset_mid_read2 step %0d: got %h, want %h", i, obs2, steps[i].exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    steps.delete();
    instr(7'b1111111, 3'b000);
    push(S_FETCH, B_FETCH_GO, 1'b0);
    push(S_DECODE, B_DECODE, 1'b0);
    push(S_ILLEGAL, B_IDLE, 1'b0);
`ifdef MULTICYCLE_ILLEGAL_HALT_EN
    for (int k = 0; k < 20; k++) push(S_HALT, B_IDLE, 1'b1);
`else
    push(S_FETCH, B_FETCH_GO, 1'b0);
    push(S_DECODE, B_DECODE, 1'b0);
`endif
    do_reset();
    foreach (steps[i]) begin
      op = steps[i].op; funct3 = steps[i].f3; zero = steps[i].z; rst = steps[i].r; #1;
      n_tests++;
      if (obs0 !== steps[i].exp) begin
        n_fail++;
        $display("FAIL illegal step %0d: got %h, want %h", i, obs0, steps[i].exp);
      end
      @(negedge clk);
    end
    // One reset edge must leave HALT (or the nop loop) cleanly.
    do_reset();
    #1;
    n_tests++;
    if (obs0 !== {S_FETCH, B_FETCH_GO, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL illegal_reset: got %h, want %h", obs0, {S_FETCH, B_FETCH_GO, 3'b000, 1'b0});
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_r_type();
    test_lw_wait();
    test_branch();
    test_jalr();
    test_back_to_back();
    test_reset_mid_store();
    test_reset_mid_read();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
